// File: rtl/load_store_unit.sv
// Load/store bus initiator: word bus without byte enables, sub-word stores via read-modify-write,
// lane-extracted loads with sign/zero extension. Define LSU_TIMEOUT_EN to enable the bus timeout.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        bus_cs,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready
);

   localparam int unsigned XLEN = 32;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_MERGE, S_WRITE, S_RESP} state_e;

   state_e            state_q, state_d;
   logic [1:0]        off_q, off_d;
   logic [1:0]        size_q, size_d;
   logic              we_q, we_d;
   logic              signed_q, signed_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              bus_cs_q, bus_cs_d;
   logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
   logic              bus_we_q, bus_we_d;
   logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
   logic              resp_fault_q, resp_fault_d;

   logic              req_fault;
   logic              tmo_hit;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [XLEN-1:0]   load_data;
   logic [XLEN-1:0]   merge_data;

   assign req_ready = rst_n && (state_q == S_IDLE);

   assign req_fault = (req_size == 2'b11)
                   || ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

   // Lane extraction for loads and lane insertion for RMW stores
   always_comb begin
      lane_b     = bus_rdata[{off_q, 3'b000} +: 8];
      lane_h     = bus_rdata[{off_q[1], 4'b0000} +: 16];
      load_data  = bus_rdata;
      merge_data = rdata_q;
      if (size_q == SZ_BYTE) begin
         load_data = {{24{signed_q & lane_b[7]}}, lane_b};
         merge_data[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end else if (size_q == SZ_HALF) begin
         load_data = {{16{signed_q & lane_h[15]}}, lane_h};
         merge_data[{off_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             bus_wait;

   assign bus_wait = ((state_q == S_READ) || (state_q == S_WRITE)) && !bus_ready;
   assign tmo_hit  = bus_wait && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   // Counter is zero outside READ/WRITE, so it starts cleared on every entry
   always_comb begin
      tmo_d = '0;
      if (bus_wait) begin
         tmo_d = tmo_q + TMO_W'(1);
      end else if ((state_q == S_READ) || (state_q == S_WRITE)) begin
         tmo_d = tmo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
   assign tmo_hit        = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      size_d       = size_q;
      we_d         = we_q;
      signed_d     = signed_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      bus_cs_d     = bus_cs_q;
      bus_addr_d   = bus_addr_q;
      bus_we_d     = bus_we_q;
      bus_wdata_d  = bus_wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_fault_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               off_d    = req_addr[1:0];
               size_d   = req_size;
               we_d     = req_we;
               signed_d = req_signed;
               wdata_d  = req_wdata[15:0];
               if (req_fault) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
               end else begin
                  bus_cs_d   = 1'b1;
                  bus_addr_d = {req_addr[31:2], 2'b00};
                  if (req_we && (req_size == SZ_WORD)) begin
                     state_d     = S_WRITE;
                     bus_we_d    = 1'b1;
                     bus_wdata_d = req_wdata;
                  end else begin
                     state_d     = S_READ;
                     bus_we_d    = 1'b0;
                     bus_wdata_d = '0;
                  end
               end
            end
         end
         S_READ: begin
            if (bus_ready) begin
               bus_cs_d = 1'b0;
               if (we_q) begin
                  state_d = S_MERGE;
                  rdata_d = bus_rdata;
               end else begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = load_data;
               end
            end else if (tmo_hit) begin
               bus_cs_d     = 1'b0;
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_fault_d = 1'b1;
            end
         end
         S_MERGE: begin
            state_d     = S_WRITE;
            bus_cs_d    = 1'b1;
            bus_we_d    = 1'b1;
            bus_wdata_d = merge_data;
         end
         S_WRITE: begin
            if (bus_ready || tmo_hit) begin
               bus_cs_d     = 1'b0;
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_fault_d = !bus_ready;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         off_q        <= '0;
         size_q       <= '0;
         we_q         <= 1'b0;
         signed_q     <= 1'b0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         bus_cs_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_we_q     <= 1'b0;
         bus_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         size_q       <= size_d;
         we_q         <= we_d;
         signed_q     <= signed_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         bus_cs_q     <= bus_cs_d;
         bus_addr_q   <= bus_addr_d;
         bus_we_q     <= bus_we_d;
         bus_wdata_q  <= bus_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_fault_q <= resp_fault_d;
      end
   end

   assign bus_cs     = bus_cs_q;
   assign bus_addr   = bus_addr_q;
   assign bus_we     = bus_we_q;
   assign bus_wdata  = bus_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, response scoreboard, responder memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_fault, bus_cs, bus_we, bus_ready;
   logic [31:0] resp_rdata, bus_addr, bus_wdata, bus_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .bus_cs(bus_cs), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready)
   );

   // Responder: registered ready after wait_n extra cycles, word memory
   logic [31:0] mem [0:255];
   logic        ready_q = 1'b0, force_rdy = 1'b0, stall_rdy = 1'b0, frc_en = 1'b0;
   int          wait_n = 0, wcnt = 0;

   assign bus_ready = (ready_q | force_rdy) & ~stall_rdy;
   assign bus_rdata = bus_ready ? mem[bus_addr[9:2]] : 32'hA5A5_5A5A;

   always @(posedge clk) begin
      if (bus_cs && bus_ready && bus_we) mem[bus_addr[9:2]] <= bus_wdata;
      ready_q <= bus_cs && (wcnt >= wait_n);
      wcnt    <= bus_cs ? wcnt + 1 : 0;
   end

   int n_chk = 0, n_fail = 0;
   int cyc = 0, acc = 0, resp_cyc = 0, resp_cnt = 0, cs_cnt = 0;
   logic [32:0] exp_q[$];
   logic [32:0] e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: scoreboard pop on responses, bus protocol checks
   logic        p_ok = 1'b0, p_cs = 1'b0, p_rdy = 1'b0, p_we = 1'b0;
   logic [31:0] p_addr = '0, p_wdata = '0;

   always @(negedge clk) begin
      if (bus_cs) cs_cnt++;
      if (resp_valid) begin
         resp_cnt++;
         resp_cyc = cyc;
         chk("resp_cs_low", 32'(bus_cs), 32'd0);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected none (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e[31:0]);
            chk("resp_fault", 32'(resp_fault), 32'(e[32]));
         end
      end
      force_rdy = frc_en && resp_valid;
      if (rst_n && p_ok) begin
         if (p_cs && !p_rdy) begin
            chk("bus_hold_ctl", 32'({bus_cs, bus_we}), 32'({1'b1, p_we}));
            chk("bus_hold_addr", bus_addr, p_addr);
            chk("bus_hold_wdata", bus_wdata, p_wdata);
         end
         if (p_cs && p_rdy) chk("bus_cs_drop", 32'(bus_cs), 32'd0);
      end
      if (bus_cs && !bus_we) chk("rd_wdata_zero", bus_wdata, 32'd0);
      p_ok = rst_n; p_cs = bus_cs; p_rdy = bus_ready; p_we = bus_we;
      p_addr = bus_addr; p_wdata = bus_wdata;
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      int          lat;
      int          cs_cyc;
      int          wt;
      logic        frc;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_fault,
                               input int lat, input int cs_cyc, input int wt, input logic frc);
      vec_t v;
      v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.lat = lat; v.cs_cyc = cs_cyc;
      v.wt = wt; v.frc = frc;
      return v;
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int start;
      int k;
      wait_n = v.wt;
      frc_en = v.frc;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 50) begin @(negedge clk); k++; end
      chk($sformatf("v%0d_req_ready", idx), 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
      req_addr = v.addr; req_wdata = v.wdata;
      start = resp_cnt;
      exp_q.push_back({v.exp_fault, v.exp_rdata});
      @(posedge clk);
      #1;
      acc = cyc;
      cs_cnt = 0;
      req_valid = 1'b0; req_we = 1'($urandom()); req_size = 2'($urandom());
      req_signed = 1'($urandom()); req_addr = $urandom(); req_wdata = $urandom();
      k = 0;
      while (resp_cnt == start && k < 100) begin @(negedge clk); k++; end
      if (resp_cnt == start) begin
         chk($sformatf("v%0d_resp_timeout", idx), 32'd0, 32'd1);
      end else begin
         chk($sformatf("v%0d_latency", idx), 32'(resp_cyc - acc + 1), 32'(v.lat));
         chk($sformatf("v%0d_cs_cycles", idx), 32'(cs_cnt), 32'(v.cs_cyc));
      end
   endtask

   vec_t vecs[$];

   initial begin
      int k;
      int rc;
      for (int i = 0; i < 256; i++) mem[i] = '0;

      //           we    sz     sgn   addr       wdata         exp_rdata     flt  lat cs wt frc
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h00000000, 1'b0, 3, 2, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 3, 2, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h101, 32'h0,        32'hFFFFFFBE, 1'b0, 3, 2, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h101, 32'h0,        32'h000000BE, 1'b0, 3, 2, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        32'hFFFFDEAD, 1'b0, 3, 2, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h100, 32'h0,        32'h0000BEEF, 1'b0, 3, 2, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h100, 32'h0,        32'hFFFFFFEF, 1'b0, 3, 2, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h000000DE, 1'b0, 3, 2, 0, 1'b0));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h102, 32'hFFFF1234, 32'h00000000, 1'b0, 6, 4, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h1234BEEF, 1'b0, 3, 2, 0, 1'b0));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h201, 32'hFFFFFF77, 32'h00000000, 1'b0, 6, 4, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h200, 32'h0,        32'h00007700, 1'b0, 3, 2, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h201, 32'h0,        32'h00000077, 1'b0, 3, 2, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h200, 32'h0,        32'h00007700, 1'b0, 3, 2, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 1'b0));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h101, 32'h5555,     32'h00000000, 1'b1, 1, 0, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h101, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 1'b0));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 32'h00000000, 1'b0, 6, 5, 3, 1'b1));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h302, 32'h00000055, 32'h00000000, 1'b0, 12, 10, 3, 1'b1));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h300, 32'h0,        32'hCA55F00D, 1'b0, 3, 2, 0, 1'b1));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h302, 32'h0,        32'h0000CA55, 1'b0, 3, 2, 0, 1'b0));

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_bus_ctl", 32'({bus_cs, bus_we}), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_resp", 32'({resp_valid, resp_fault}), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);
      chk("mem_half_rmw", mem[8'h40], 32'h1234BEEF);
      chk("mem_byte_rmw", mem[8'hC0], 32'hCA55F00D);

      // Reset during the WRITE phase of a byte-store RMW
      wait_n = 0;
      frc_en = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h301; req_wdata = 32'h000000AB;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      k = 0;
      while (!(bus_cs && bus_we) && k < 20) begin @(negedge clk); k++; end
      chk("rmw_reach_write", 32'(bus_cs && bus_we), 32'd1);
      rc = resp_cnt;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      chk("midrst_bus_ctl", 32'({bus_cs, bus_we}), 32'd0);
      chk("midrst_bus_addr", bus_addr, 32'd0);
      chk("midrst_bus_wdata", bus_wdata, 32'd0);
      chk("midrst_resp", 32'({resp_valid, resp_fault}), 32'd0);
      chk("midrst_resp_rdata", resp_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("midrst_no_resp", 32'(resp_cnt), 32'(rc));
      chk("midrst_mem_kept", mem[8'hC0], 32'hCA55F00D);
      run_vec(100, mk(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hCA55F00D, 1'b0, 3, 2, 0, 1'b0));

`ifdef LSU_TIMEOUT_EN
      stall_rdy = 1'b1;
      run_vec(200, mk(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h00000000, 1'b1, 17, 16, 0, 1'b0));
      stall_rdy = 1'b0;
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Bus initiator that turns core load/store requests into transactions on the word-wide `cs/addr/we/wdata/rdata/ready` memory bus. The BRAM stack and the other memory responders sit on the far side of this bus. The block handles byte and half-word access with no byte enables on the bus: sub-word stores become read-modify-write, and loads are lane-extracted with sign or zero extension. It sits between the CPU execute stage and the bus decoder.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles to wait for `bus_ready` before aborting (used only with `LSU_TIMEOUT_EN`).
- `clk` in 1: clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: core request present.
- `req_ready` out 1: high in IDLE only; a request is accepted on an edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend loads.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse; there is no backpressure.
- `resp_rdata` out 32: extended load data; 0 for stores and faults.
- `resp_fault` out 1: misaligned, illegal size, or timeout.
- `bus_cs` out 1: transaction request.
- `bus_addr` out 32: `{req_addr[31:2],2'b00}`.
- `bus_we` out 1: write.
- `bus_wdata` out 32: write word; 0 on reads.
- `bus_rdata` in 32: valid when `bus_ready` is high.
- `bus_ready` in 1: completion; the responder drives it as a registered copy of `cs`.

## Operation
- States:
  - IDLE
  - READ
  - MERGE
  - WRITE
  - RESP
- Request address and data are latched at acceptance.
- Alignment check at acceptance:
  - Half with `addr[0]=1` faults.
  - Word with `addr[1:0]!=0` faults.
  - Size 11 faults.
  - A faulting request goes IDLE→RESP with `resp_fault=1` and issues no bus transaction.
- Load: IDLE→READ→RESP.
- Word store: IDLE→WRITE→RESP.
- Byte/half store: IDLE→READ→MERGE→WRITE→RESP.
- MERGE replaces the addressed lane(s) of the read word with `req_wdata[7:0]` or `req_wdata[15:0]`. Lanes are little-endian, selected by `addr[1:0]`.
- Load extraction:
  - Byte lane is `addr[1:0]`; half lane is `addr[1]`.
  - Result is zero- or sign-extended per `req_signed`.
  - Word loads are passed through unchanged.
- Bus rules:
  - In READ and WRITE, `bus_cs`, `bus_addr`, `bus_we` and `bus_wdata` are held stable until an edge where `bus_ready=1` is sampled.
  - `bus_cs` drops on that edge.
  - `bus_ready` is ignored whenever `bus_cs=0`. This covers the stale `ready` that follows every transaction.
  - `bus_cs` is low for at least one cycle between any two transactions. MERGE and RESP provide this gap.
- RESP lasts 1 cycle: `resp_valid=1`, then IDLE.
- `req_*` inputs are ignored outside IDLE.

## Timing
- Reset values (at the edge where `rst_n=0`):
  - State = IDLE.
  - `bus_cs`, `bus_we`, `bus_addr`, `bus_wdata` = 0.
  - `resp_valid`, `resp_rdata`, `resp_fault` = 0.
- `req_ready=0` while `rst_n=0`; otherwise `req_ready = (state==IDLE)`.
- All bus and resp outputs are registered.
- With a zero-wait responder (`ready` one cycle after `cs`):
  - Acceptance on edge E0.
  - `bus_cs=1` in cycles E0+1 and E0+2.
  - Load or word store: `resp_valid` in cycle E0+3; next acceptance no earlier than E0+4.
  - Sub-word store: READ in E0+1..2, MERGE in E0+3, WRITE in E0+4..5, `resp_valid` in E0+6.
  - Fault: `resp_valid` in cycle E0+1.
- Each extra responder wait cycle extends READ or WRITE by one cycle.
- Reset mid-operation: takes effect at the next edge and aborts any transaction. No `resp_valid` is produced for the aborted request, and a partial RMW write is never issued after reset.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit counter clears on entry to READ or WRITE and increments each cycle `bus_ready=0`.
  - When it reaches `TIMEOUT_CYCLES`, `bus_cs` drops and the FSM goes to RESP with `resp_fault=1` and `resp_rdata=0`.
  - An RMW that times out in READ does not write.
- `LSU_TIMEOUT_EN` undefined: no counter; READ and WRITE wait indefinitely.

## Test plan
- Word store `0xDEADBEEF` @ `0x100`, then word load @ `0x100`:
  - `resp_rdata=0xDEADBEEF`, `resp_fault=0`.
  - `bus_cs` high exactly 2 cycles per access.
  - Response latency 3 cycles.
- After the word store, loads @ `0x101`:
  - Signed byte → `0xFFFFFFBE`.
  - Unsigned byte → `0x000000BE`.
  - Signed half @ `0x102` → `0xFFFFDEAD`.
- Half store `0x1234` @ `0x102`, then word load @ `0x100`:
  - Load returns `0x1234BEEF`.
  - Bus sees a read, one `cs`-low cycle, then a write of `0x1234BEEF`.
  - `resp_valid` 6 cycles after acceptance.
- Misaligned and illegal requests:
  - Word load @ `0x102`, half store @ `0x101`, size 11 @ `0x100`.
  - Each gives `resp_fault=1` and `resp_rdata=0` one cycle after acceptance, with `bus_cs` never asserted.
- Responder inserting 3 wait cycles, plus `bus_ready` forced high during the RESP gap:
  - Address and data are held stable throughout.
  - The stale `ready` is ignored.
  - The next request is unaffected.
- `rst_n` low during WRITE of a byte-store RMW:
  - All outputs read 0 after the edge.
  - No `resp_valid`.
  - Memory word unchanged.
- With `LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`, `bus_ready` tied 0:
  - Fault response after 16 wait cycles.
  - `bus_cs` low in the RESP cycle.
